// File: rtl/nfc_pkg.sv
// Shared constants and FSM encoding for the NFC buffer RAM family.
package nfc_pkg;

    localparam int NFC_BYTE  = 8;
    localparam int NFC_WIDTH = 16;
    localparam int NFC_ADDR  = 4;
    localparam int NFC_DEPTH = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } nfc_state_t;

endpackage

// File: rtl/nfc_byte_ram_if.sv
// Host-side port bundle of the NFC byte-lane RAM.
interface nfc_byte_ram_if #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4
);
    localparam int BYTES = WIDTH / 8;

    logic [BYTES-1:0] write;
    logic             read;
    logic [ADDR-1:0]  addr_wr;
    logic [ADDR-1:0]  addr_rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             init_busy;

    modport master (
        output write, read, addr_wr, addr_rd, data_in,
        input  data_out, rd_valid, init_busy
    );

    modport slave (
        input  write, read, addr_wr, addr_rd, data_in,
        output data_out, rd_valid, init_busy
    );

endinterface

// File: rtl/nfc_ram_core.sv
// Bare byte-lane storage array: lane-masked write port, registered read address,
// combinational array output (block-RAM friendly).
module nfc_ram_core
    import nfc_pkg::*;
#(
    parameter int WIDTH = NFC_WIDTH,
    parameter int ADDR  = NFC_ADDR,
    parameter int DEPTH = NFC_DEPTH
) (
    input  logic                  clk,
    input  logic [WIDTH/8-1:0]    we,
    input  logic [ADDR-1:0]       wa,
    input  logic [WIDTH-1:0]      wd,
    input  logic                  rd_en,
    input  logic [ADDR-1:0]       ra,
    output logic [WIDTH-1:0]      rd
);

    localparam int BYTES = WIDTH / NFC_BYTE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  ra_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[wa][i*NFC_BYTE +: NFC_BYTE] <= wd[i*NFC_BYTE +: NFC_BYTE];
            end
        end
        if (rd_en) begin
            ra_reg <= ra;
        end
    end

    // Reads after a same-edge write see the new lanes, since the address is registered.
    assign rd = mem[ra_reg];

endmodule

// File: rtl/nfc_byte_ram.sv
// NFC byte-lane buffer RAM: post-reset clear sweep, write-first collision merge,
// out-of-range masking and an optional extra output register.
module nfc_byte_ram
    import nfc_pkg::*;
#(
    parameter int WIDTH    = NFC_WIDTH,
    parameter int ADDR     = NFC_ADDR,
    parameter int DEPTH    = NFC_DEPTH,
    parameter int OUT_REG  = 0,
    parameter int INIT_CLR = 1
) (
    input  logic          clk,
    input  logic          rst,
    nfc_byte_ram_if.slave bus
);

    localparam int BYTES = WIDTH / NFC_BYTE;
    localparam logic [ADDR:0]   DEPTH_W  = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_CLR = ADDR'(DEPTH - 1);

    if (WIDTH % NFC_BYTE != 0) begin : g_bad_width
        $error("nfc_byte_ram: WIDTH must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR)) begin : g_bad_depth
        $error("nfc_byte_ram: DEPTH exceeds 2**ADDR");
    end

    function automatic logic in_range(input logic [ADDR-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    nfc_state_t       state_reg;
    logic [ADDR-1:0]  clr_cnt_reg;
    logic             init_busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= (INIT_CLR != 0) ? ST_INIT : ST_RUN;
            clr_cnt_reg   <= '0;
            init_busy_reg <= (INIT_CLR != 0);
        end else if (state_reg == ST_INIT) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == LAST_CLR) begin
                state_reg     <= ST_RUN;
                init_busy_reg <= 1'b0;
            end
        end
    end

    assign bus.init_busy = init_busy_reg;

    logic             run;
    logic             rd_go;
    logic [BYTES-1:0] mem_we;
    logic [ADDR-1:0]  mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] ram_q;

    assign run   = (state_reg == ST_RUN);
    assign rd_go = run && bus.read;

    // Sweep owns the write port during INIT; a write coincident with rst is dropped.
    always_comb begin
        mem_we = '0;
        mem_wa = bus.addr_wr;
        mem_wd = bus.data_in;
        if (!rst) begin
            if (!run) begin
                mem_we = '1;
                mem_wa = clr_cnt_reg;
                mem_wd = '0;
            end else if (in_range(bus.addr_wr)) begin
                mem_we = bus.write;
            end
        end
    end

    nfc_ram_core #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .wa    (mem_wa),
        .wd    (mem_wd),
        .rd_en (rd_go),
        .ra    (bus.addr_rd),
        .rd    (ram_q)
    );

    logic             rd_v1_reg;
    logic             oor_reg;
    logic [BYTES-1:0] coll_mask_reg;
    logic [WIDTH-1:0] coll_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1_reg     <= 1'b0;
            oor_reg       <= 1'b0;
            coll_mask_reg <= '0;
            coll_data_reg <= '0;
        end else begin
            rd_v1_reg     <= rd_go;
            oor_reg       <= !in_range(bus.addr_rd);
            coll_mask_reg <= (rd_go && bus.addr_rd == bus.addr_wr && in_range(bus.addr_wr))
                             ? bus.write : '0;
            coll_data_reg <= bus.data_in;
        end
    end

    logic [WIDTH-1:0] merged_raw;
    logic [WIDTH-1:0] merged;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign merged_raw[gi*NFC_BYTE +: NFC_BYTE] = coll_mask_reg[gi]
            ? coll_data_reg[gi*NFC_BYTE +: NFC_BYTE]
            : ram_q[gi*NFC_BYTE +: NFC_BYTE];
    end

    assign merged = oor_reg ? '0 : merged_raw;

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] data_reg;
        logic             valid_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= rd_v1_reg;
                if (rd_v1_reg) begin
                    data_reg <= merged;
                end
            end
        end

        assign bus.data_out = data_reg;
        assign bus.rd_valid = valid_reg;
    end else begin : g_out_direct
        logic [WIDTH-1:0] hold_reg;

        // Fresh word shows in the result cycle; the hold register keeps it afterwards.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_reg <= '0;
            end else if (rd_v1_reg) begin
                hold_reg <= merged;
            end
        end

        assign bus.data_out = rd_v1_reg ? merged : hold_reg;
        assign bus.rd_valid = rd_v1_reg;
    end

endmodule

// File: tb/tb_nfc_byte_ram.sv
// Directed bench for nfc_byte_ram: three configurations sharing one clock.
module tb_nfc_byte_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    nfc_byte_ram_if #(.WIDTH(16), .ADDR(4)) bus_a();
    nfc_byte_ram_if #(.WIDTH(32), .ADDR(4)) bus_b();
    nfc_byte_ram_if #(.WIDTH(16), .ADDR(4)) bus_c();

    nfc_byte_ram #(.WIDTH(16), .ADDR(4), .DEPTH(16), .OUT_REG(0), .INIT_CLR(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    nfc_byte_ram #(.WIDTH(32), .ADDR(4), .DEPTH(16), .OUT_REG(1), .INIT_CLR(1))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
    nfc_byte_ram #(.WIDTH(16), .ADDR(4), .DEPTH(12), .OUT_REG(0), .INIT_CLR(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic wr_a(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] m);
        bus_a.addr_wr = ad; bus_a.data_in = d; bus_a.write = m;
        @(negedge clk);
        bus_a.write = '0;
    endtask

    task automatic rd_a(input string tag, input logic [3:0] ad, input logic [31:0] exp);
        bus_a.addr_rd = ad; bus_a.read = 1'b1;
        @(negedge clk);
        bus_a.read = 1'b0;
        check_eq({tag, "_data"}, 32'(bus_a.data_out), exp);
        check_eq({tag, "_valid"}, 32'(bus_a.rd_valid), 32'd1);
    endtask

    task automatic wr_b(input logic [3:0] ad, input logic [31:0] d);
        bus_b.addr_wr = ad; bus_b.data_in = d; bus_b.write = 4'hF;
        @(negedge clk);
        bus_b.write = '0;
    endtask

    task automatic rd_b(input string tag, input logic [3:0] ad, input logic [31:0] exp);
        bus_b.addr_rd = ad; bus_b.read = 1'b1;
        @(negedge clk);
        bus_b.read = 1'b0;
        check_eq({tag, "_early"}, 32'(bus_b.rd_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_data"}, bus_b.data_out, exp);
        check_eq({tag, "_valid"}, 32'(bus_b.rd_valid), 32'd1);
    endtask

    task automatic wr_c(input logic [3:0] ad, input logic [15:0] d);
        bus_c.addr_wr = ad; bus_c.data_in = d; bus_c.write = 2'b11;
        @(negedge clk);
        bus_c.write = '0;
    endtask

    task automatic rd_c(input string tag, input logic [3:0] ad, input logic [31:0] exp);
        bus_c.addr_rd = ad; bus_c.read = 1'b1;
        @(negedge clk);
        bus_c.read = 1'b0;
        check_eq({tag, "_data"}, 32'(bus_c.data_out), exp);
        check_eq({tag, "_valid"}, 32'(bus_c.rd_valid), 32'd1);
    endtask

    int cnt_a, cnt_b, cnt_c;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.write = '0; bus_a.read = 1'b0; bus_a.addr_wr = '0; bus_a.addr_rd = '0; bus_a.data_in = '0;
        bus_b.write = '0; bus_b.read = 1'b0; bus_b.addr_wr = '0; bus_b.addr_rd = '0; bus_b.data_in = '0;
        bus_c.write = '0; bus_c.read = 1'b0; bus_c.addr_wr = '0; bus_c.addr_rd = '0; bus_c.data_in = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_a_data", 32'(bus_a.data_out), 32'h0);
        check_eq("rst_a_valid", 32'(bus_a.rd_valid), 32'h0);
        check_eq("rst_a_busy", 32'(bus_a.init_busy), 32'h1);
        check_eq("rst_b_busy", 32'(bus_b.init_busy), 32'h1);
        check_eq("rst_b_data", bus_b.data_out, 32'h0);
        check_eq("rst_c_busy", 32'(bus_c.init_busy), 32'h1);

        // Sweep length: count samples with init_busy high, bounded.
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            cnt_a = cnt_a + 32'(bus_a.init_busy);
            cnt_b = cnt_b + 32'(bus_b.init_busy);
            cnt_c = cnt_c + 32'(bus_c.init_busy);
            @(negedge clk);
        end
        check_eq("sweep_a_cycles", 32'(cnt_a), 32'd16);
        check_eq("sweep_b_cycles", 32'(cnt_b), 32'd16);
        check_eq("sweep_c_cycles", 32'(cnt_c), 32'd12);
        check_eq("sweep_a_done", 32'(bus_a.init_busy), 32'h0);

        // Back-to-back reads of the freshly cleared array.
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check_eq("t1_data", 32'(bus_a.data_out), 32'h0);
                check_eq("t1_valid", 32'(bus_a.rd_valid), 32'h1);
            end
            bus_a.read    = (i < 16);
            bus_a.addr_rd = 4'(i);
            @(negedge clk);
        end

        // Byte-lane masking.
        wr_a(4'd3, 16'hABCD, 2'b11);
        wr_a(4'd3, 16'h1234, 2'b01);
        rd_a("t2_lane", 4'd3, 32'h0000AB34);
        @(negedge clk);
        check_eq("t2_hold_data", 32'(bus_a.data_out), 32'h0000AB34);
        check_eq("t2_hold_valid", 32'(bus_a.rd_valid), 32'h0);

        // Write-first collision.
        wr_a(4'd5, 16'h5555, 2'b11);
        bus_a.addr_wr = 4'd5; bus_a.data_in = 16'hAAAA; bus_a.write = 2'b10;
        rd_a("t3_coll", 4'd5, 32'h0000AA55);
        rd_a("t3_after", 4'd5, 32'h0000AA55);

        // OUT_REG=1 pipelined reads.
        wr_b(4'd0, 32'h11111111);
        wr_b(4'd1, 32'h22222222);
        wr_b(4'd2, 32'h33333333);
        bus_b.read = 1'b1; bus_b.addr_rd = 4'd0;
        @(negedge clk);
        check_eq("t4_lat_valid", 32'(bus_b.rd_valid), 32'h0);
        bus_b.addr_rd = 4'd1;
        @(negedge clk);
        check_eq("t4_r0_data", bus_b.data_out, 32'h11111111);
        check_eq("t4_r0_valid", 32'(bus_b.rd_valid), 32'h1);
        bus_b.addr_rd = 4'd2;
        @(negedge clk);
        check_eq("t4_r1_data", bus_b.data_out, 32'h22222222);
        check_eq("t4_r1_valid", 32'(bus_b.rd_valid), 32'h1);
        bus_b.read = 1'b0;
        @(negedge clk);
        check_eq("t4_r2_data", bus_b.data_out, 32'h33333333);
        check_eq("t4_r2_valid", 32'(bus_b.rd_valid), 32'h1);
        @(negedge clk);
        check_eq("t4_hold_data", bus_b.data_out, 32'h33333333);
        check_eq("t4_hold_valid", 32'(bus_b.rd_valid), 32'h0);

        // Out-of-range access on the DEPTH=12 instance.
        wr_c(4'd11, 16'h1357);
        wr_c(4'd13, 16'hFFFF);
        rd_c("t5_oor13", 4'd13, 32'h0);
        rd_c("t5_oor12", 4'd12, 32'h0);
        for (int i = 0; i < 12; i++) begin
            rd_c("t5_inrange", 4'(i), (i == 11) ? 32'h1357 : 32'h0);
        end

        // Reset with a read in flight and a write coincident with rst.
        bus_b.addr_rd = 4'd1; bus_b.read = 1'b1;
        @(negedge clk);
        bus_b.read = 1'b0;
        bus_b.addr_wr = 4'd7; bus_b.data_in = 32'hDEADBEEF; bus_b.write = 4'hF;
        rst_b = 1'b1;
        #1;
        check_eq("t6_async_data", bus_b.data_out, 32'h0);
        check_eq("t6_async_valid", 32'(bus_b.rd_valid), 32'h0);
        @(negedge clk);
        check_eq("t6_inflight_valid", 32'(bus_b.rd_valid), 32'h0);
        rst_b = 1'b0;
        bus_b.addr_wr = 4'd4; bus_b.data_in = 32'hCAFEF00D;
        bus_b.addr_rd = 4'd4; bus_b.read = 1'b1;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_b.init_busy) begin
                cnt_b++;
                check_eq("t6_init_valid", 32'(bus_b.rd_valid), 32'h0);
            end else begin
                bus_b.write = '0; bus_b.read = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("t6_resweep_cycles", 32'(cnt_b), 32'd16);
        check_eq("t6_init_data", bus_b.data_out, 32'h0);
        rd_b("t6_rst_write", 4'd7, 32'h0);
        rd_b("t6_init_write", 4'd4, 32'h0);
        rd_b("t6_cleared", 4'd1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nfc_byte_ram.md
Name: nfc_byte_ram

Overview:
Single-clock, byte-lane-masked dual-port RAM (one write port, one read port) for NFC data buffering. Generalises the NFC buffer RAM in four ways:
- arbitrary data width with one write enable per byte lane;
- registered, held read data with a read-valid strobe;
- optional extra output pipeline stage;
- write-first read/write collision handling.
Adds a post-reset clear sweep, so downstream logic never reads stale data after reset. Sits between the NFC host-side register interface and the flash-side data path.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8 (elaboration error otherwise).
ADDR, 4, address width.
DEPTH, 16, number of entries; must satisfy DEPTH <= 2**ADDR.
OUT_REG, 0, 0 gives 1-cycle read latency; 1 gives 2-cycle read latency (extra output register).
INIT_CLR, 1, 1 enables a zero-fill sweep after reset; 0 skips it.
BYTES, WIDTH/8, localparam giving the byte-lane count.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
write  input  BYTES  per-byte-lane write enable; bit i enables data_in[8i+7:8i].
read  input  1  read request.
addr_wr  input  ADDR  write address.
addr_rd  input  ADDR  read address.
data_in  input  WIDTH  write data.
data_out  output  WIDTH  registered read data; holds its value between reads.
rd_valid  output  1  one-cycle strobe; data_out is new this cycle.
init_busy  output  1  high while the clear sweep runs; port accesses are ignored.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: data_out=0, rd_valid=0, read pipeline valid bits=0, clear counter=0. init_busy=1 if INIT_CLR=1, else 0. RAM array is not reset.
- FSM states: INIT, RUN.
  - rst asserts -> INIT if INIT_CLR=1, else RUN.
  - In INIT, each cycle: ram[clr_cnt] <= 0, clr_cnt++.
  - The cycle clr_cnt==DEPTH-1 is written -> RUN.
  - The sweep takes exactly DEPTH cycles after rst deasserts; init_busy drops on the edge that enters RUN.
- INIT: write and read are ignored. No RAM update from the port, no rd_valid, data_out stays 0.
- Write (RUN): at the clk edge, for each i with write[i]=1, ram[addr_wr] byte i <= data_in byte i. Other lanes are untouched. write=0 is a no-op.
- Read (RUN): read=1 at edge t samples addr_rd.
  - OUT_REG=0: data_out updated and rd_valid=1 in cycle t+1.
  - OUT_REG=1: data_out updated and rd_valid=1 in cycle t+2.
  - Back-to-back reads give one result per cycle, fully pipelined.
  - With read=0, rd_valid=0 in the matching result cycle and data_out holds its value.
- Collision (write-first): read and write in the same cycle with addr_rd==addr_wr and address < DEPTH.
  - Returned word = data_in for lanes with write[i]=1, old contents for the other lanes.
  - The RAM is updated normally.
- Out of range (DEPTH < 2**ADDR): write to addr >= DEPTH is dropped. Read from addr >= DEPTH returns 0 with rd_valid=1.
- Reset mid-operation:
  - In-flight reads are discarded (rd_valid stays 0) and data_out is cleared immediately (asynchronous).
  - A write coincident with rst is lost.
  - The sweep restarts from address 0.
- No combinational path from any input to data_out or rd_valid.

Decomposition:
- Shared package nfc_pkg:
  - NFC_BYTE = 8;
  - FSM state encoding (ST_INIT=1'b0, ST_RUN=1'b1);
  - default NFC buffer WIDTH, ADDR and DEPTH constants.
- Sub-module nfc_ram_core: the bare storage array. One write port with BYTES lane enables, one synchronous read-address register, combinational array output.
- nfc_byte_ram owns the FSM, clear counter, collision merge, range check and output pipeline.

Test Plan:
1. Reset, INIT_CLR=1, DEPTH=16, ADDR=4, WIDTH=16: deassert rst -> init_busy=1 for exactly 16 cycles. Then read addr 0..15 -> every data_out=16'h0000, rd_valid=1 in each result cycle.
2. Byte-lane masking, OUT_REG=0, WIDTH=16, ADDR=4: write 16'hABCD to addr 3 with write=2'b11, then 16'h1234 with write=2'b01. Read addr 3 -> one cycle later data_out=16'hAB34, rd_valid=1.
3. Collision, WIDTH=16: addr 5 holds 16'h5555. Same cycle: write 16'hAAAA with write=2'b10, read addr 5 -> data_out=16'hAA55. A following read of addr 5 -> 16'hAA55.
4. OUT_REG=1, WIDTH=32 (BYTES=4), DEPTH=16, ADDR=4: back-to-back reads of addr 0,1,2 holding 32'h11111111, 32'h22222222, 32'h33333333 -> these appear in cycles t+2, t+3, t+4, rd_valid high for three consecutive cycles. data_out holds 32'h33333333 afterwards with rd_valid=0.
5. DEPTH=12, ADDR=4: write 16'hFFFF to addr 13, then read addr 13 -> data_out=16'h0000, rd_valid=1. Addr 0..11 are unchanged.
6. Reset mid-operation: assert rst one cycle after a read request (OUT_REG=1) -> data_out=0 immediately, no rd_valid pulse. Sweep restarts, and a write attempted during init_busy=1 is not visible after INIT.
